// File: rtl/alu_exec.sv
// Integer execution unit: single-cycle RV32I ALU/branch compare plus iterative RV32M divide/multiply.
// Define ALU_FAST_MUL_EN to make MUL/MULH/MULHSU/MULHU single-cycle; DIV/REM stay iterative.

`ifndef WORD_TP
`define WORD_TP logic [31:0]
`endif
`ifndef ROB_IDX_TP
`define ROB_IDX_TP logic [4:0]
`endif
`ifndef INST_OPT_TP
`define INST_OPT_TP logic [5:0]
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'd0
`endif
`ifndef ZERO_ROB_IDX
`define ZERO_ROB_IDX 5'd0
`endif

module alu_exec #(
  parameter int ITER_BIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       alu_rb,
  input  logic       alu_ena,
  input  `INST_OPT_TP alu_opt,
  input  `WORD_TP    alu_val1,
  input  `WORD_TP    alu_val2,
  input  `WORD_TP    alu_imm,
  input  `ROB_IDX_TP alu_rob_idx,
  output logic       alu_busy,
  output logic       cdb_alu_valid,
  output `ROB_IDX_TP cdb_alu_src,
  output `WORD_TP    cdb_alu_val
);

  localparam logic [5:0] OPT_ADD   = 6'd0,  OPT_SUB   = 6'd1,  OPT_SLL   = 6'd2,  OPT_SLT   = 6'd3;
  localparam logic [5:0] OPT_SLTU  = 6'd4,  OPT_XOR   = 6'd5,  OPT_SRL   = 6'd6,  OPT_SRA   = 6'd7;
  localparam logic [5:0] OPT_OR    = 6'd8,  OPT_AND   = 6'd9,  OPT_ADDI  = 6'd10, OPT_SLTI  = 6'd11;
  localparam logic [5:0] OPT_SLTIU = 6'd12, OPT_XORI  = 6'd13, OPT_ORI   = 6'd14, OPT_ANDI  = 6'd15;
  localparam logic [5:0] OPT_SLLI  = 6'd16, OPT_SRLI  = 6'd17, OPT_SRAI  = 6'd18, OPT_BEQ   = 6'd19;
  localparam logic [5:0] OPT_BNE   = 6'd20, OPT_BLT   = 6'd21, OPT_BGE   = 6'd22, OPT_BLTU  = 6'd23;
  localparam logic [5:0] OPT_BGEU  = 6'd24, OPT_MUL   = 6'd25, OPT_MULH  = 6'd26, OPT_MULHSU = 6'd27;
  localparam logic [5:0] OPT_MULHU = 6'd28, OPT_DIV   = 6'd29, OPT_DIVU  = 6'd30, OPT_REM   = 6'd31;
  localparam logic [5:0] OPT_REMU  = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [5:0] opt);
`ifdef ALU_FAST_MUL_EN
    return (opt >= OPT_DIV) && (opt <= OPT_REMU);
`else
    return (opt >= OPT_MUL) && (opt <= OPT_REMU);
`endif
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return 32'd0 - x;
  endfunction

  state_t              state_q, state_d;
  logic [ITER_BIT-1:0] cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [4:0]          src_q, src_d, tag_q, tag_d;
  logic [31:0]         val_q, val_d, opa_q, opa_d, opb_q, opb_d;
  logic [63:0]         acc_q, acc_d;
  logic [5:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;

  logic [31:0] op_b_s, sc_res_s, fin_res_s, a_abs_s, b_abs_s;
  logic [4:0]  shamt_s;
  logic        multi_s, a_neg_s, b_neg_s, is_mul_s;
  logic [32:0] mul_sum_s, div_try_s;
  logic [31:0] div_diff_s, quo_fix_s, rem_fix_s;
  logic [63:0] mul_step_s, div_step_s, prod_fix_s;

  assign multi_s       = is_iter_op(alu_opt);
  assign alu_busy      = (state_q != S_IDLE) | (alu_ena & multi_s);
  assign cdb_alu_valid = valid_q;
  assign cdb_alu_src   = src_q;
  assign cdb_alu_val   = val_q;

`ifdef ALU_FAST_MUL_EN
  logic [63:0] fm_a_s, fm_b_s, fm_prod_s;

  // Operands extended per MULH* signedness; the low 64 bits of the product are exact.
  always_comb begin
    fm_a_s    = {{32{alu_val1[31] & ((alu_opt == OPT_MULH) | (alu_opt == OPT_MULHSU))}}, alu_val1};
    fm_b_s    = {{32{alu_val2[31] & (alu_opt == OPT_MULH)}}, alu_val2};
    fm_prod_s = fm_a_s * fm_b_s;
  end
`endif

  // Single-cycle result.
  always_comb begin
    op_b_s   = ((alu_opt >= OPT_ADDI) && (alu_opt <= OPT_SRAI)) ? alu_imm : alu_val2;
    shamt_s  = op_b_s[4:0];
    sc_res_s = 32'd0;
    case (alu_opt)
      OPT_ADD,  OPT_ADDI:  sc_res_s = alu_val1 + op_b_s;
      OPT_SUB:             sc_res_s = alu_val1 - op_b_s;
      OPT_SLL,  OPT_SLLI:  sc_res_s = alu_val1 << shamt_s;
      OPT_SLT,  OPT_SLTI:  sc_res_s = {31'd0, $signed(alu_val1) < $signed(op_b_s)};
      OPT_SLTU, OPT_SLTIU: sc_res_s = {31'd0, alu_val1 < op_b_s};
      OPT_XOR,  OPT_XORI:  sc_res_s = alu_val1 ^ op_b_s;
      OPT_SRL,  OPT_SRLI:  sc_res_s = alu_val1 >> shamt_s;
      OPT_SRA,  OPT_SRAI:  sc_res_s = 32'($signed(alu_val1) >>> shamt_s);
      OPT_OR,   OPT_ORI:   sc_res_s = alu_val1 | op_b_s;
      OPT_AND,  OPT_ANDI:  sc_res_s = alu_val1 & op_b_s;
      OPT_BEQ:             sc_res_s = {31'd0, alu_val1 == op_b_s};
      OPT_BNE:             sc_res_s = {31'd0, alu_val1 != op_b_s};
      OPT_BLT:             sc_res_s = {31'd0, $signed(alu_val1) < $signed(op_b_s)};
      OPT_BGE:             sc_res_s = {31'd0, $signed(alu_val1) >= $signed(op_b_s)};
      OPT_BLTU:            sc_res_s = {31'd0, alu_val1 < op_b_s};
      OPT_BGEU:            sc_res_s = {31'd0, alu_val1 >= op_b_s};
`ifdef ALU_FAST_MUL_EN
      OPT_MUL:             sc_res_s = fm_prod_s[31:0];
      OPT_MULH, OPT_MULHSU, OPT_MULHU: sc_res_s = fm_prod_s[63:32];
`endif
      default:             sc_res_s = 32'd0;
    endcase
  end

  // Operand magnitudes/signs captured on acceptance; the datapath works on magnitudes.
  always_comb begin
    is_mul_s = (alu_opt >= OPT_MUL) && (alu_opt <= OPT_MULHU);
    a_neg_s  = alu_val1[31] & ((alu_opt == OPT_DIV) | (alu_opt == OPT_REM) |
                               (alu_opt == OPT_MULH) | (alu_opt == OPT_MULHSU));
    b_neg_s  = alu_val2[31] & ((alu_opt == OPT_DIV) | (alu_opt == OPT_REM) | (alu_opt == OPT_MULH));
    a_abs_s  = a_neg_s ? neg32(alu_val1) : alu_val1;
    b_abs_s  = b_neg_s ? neg32(alu_val2) : alu_val2;
  end

  // One shift-add multiply step and one restoring-divide step on the shared accumulator.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    mul_step_s = {mul_sum_s, acc_q[31:1]};
    div_try_s  = acc_q[63:31];
    div_diff_s = div_try_s[31:0] - opb_q;
    div_step_s = (div_try_s >= {1'b0, opb_q}) ? {div_diff_s, acc_q[30:0], 1'b1}
                                              : {div_try_s[31:0], acc_q[30:0], 1'b0};
  end

  // Sign fix-up and final result selection.
  always_comb begin
    if (opb_q == 32'd0) begin
      quo_fix_s = 32'hFFFF_FFFF;
      rem_fix_s = sa_q ? neg32(opa_q) : opa_q;
    end else begin
      quo_fix_s = (sa_q ^ sb_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
      rem_fix_s = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];
    end
    prod_fix_s = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
    case (op_q)
      OPT_MUL:                         fin_res_s = prod_fix_s[31:0];
      OPT_MULH, OPT_MULHSU, OPT_MULHU: fin_res_s = prod_fix_s[63:32];
      OPT_DIV,  OPT_DIVU:              fin_res_s = quo_fix_s;
      OPT_REM,  OPT_REMU:              fin_res_s = rem_fix_s;
      default:                         fin_res_s = 32'd0;
    endcase
  end

  // Next-state and CDB next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    src_d   = src_q;
    val_d   = val_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (alu_ena && multi_s) begin
          state_d = S_ITER;
          cnt_d   = {ITER_BIT{1'b0}};
          opa_d   = a_abs_s;
          opb_d   = b_abs_s;
          acc_d   = is_mul_s ? {32'd0, b_abs_s} : {32'd0, a_abs_s};
          op_d    = alu_opt;
          sa_d    = a_neg_s;
          sb_d    = b_neg_s;
          tag_d   = alu_rob_idx;
        end else if (alu_ena) begin
          valid_d = 1'b1;
          src_d   = alu_rob_idx;
          val_d   = sc_res_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        acc_d   = ((op_q >= OPT_MUL) && (op_q <= OPT_MULHU)) ? mul_step_s : div_step_s;
        cnt_d   = cnt_q + {{(ITER_BIT-1){1'b0}}, 1'b1};
        state_d = (cnt_q == {ITER_BIT{1'b1}}) ? S_FIN : S_ITER;
      end
      S_FIN: begin
        valid_d = 1'b1;
        src_d   = tag_q;
        val_d   = fin_res_s;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registers: reset/rollback dominate, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst || alu_rb) begin
      state_q <= S_IDLE;
      cnt_q   <= {ITER_BIT{1'b0}};
      valid_q <= 1'b0;
      src_q   <= `ZERO_ROB_IDX;
      val_q   <= `ZERO_WORD;
      acc_q   <= 64'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      op_q    <= 6'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      tag_q   <= 5'd0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      val_q   <= val_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed spec cases plus randomized ops against an arithmetic model.
module tb_alu_exec;

  localparam logic [5:0] OPT_ADD = 6'd0, OPT_SUB = 6'd1, OPT_ADDI = 6'd10, OPT_SLTI = 6'd11;
  localparam logic [5:0] OPT_SRAI = 6'd18, OPT_BLTU = 6'd23, OPT_MUL = 6'd25, OPT_MULHU = 6'd28;
  localparam logic [5:0] OPT_DIV = 6'd29, OPT_DIVU = 6'd30, OPT_REM = 6'd31, OPT_REMU = 6'd32;
`ifdef ALU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, alu_rb, alu_ena;
  logic [5:0]  alu_opt;
  logic [31:0] alu_val1, alu_val2, alu_imm;
  logic [4:0]  alu_rob_idx;
  logic        alu_busy, cdb_alu_valid;
  logic [4:0]  cdb_alu_src;
  logic [31:0] cdb_alu_val;
  int checks = 0;
  int errors = 0;

  alu_exec dut (
    .clk(clk), .rst(rst), .rdy(rdy), .alu_rb(alu_rb), .alu_ena(alu_ena), .alu_opt(alu_opt),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx),
    .alu_busy(alu_busy), .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src),
    .cdb_alu_val(cdb_alu_val)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  function automatic bit is_multi(input logic [5:0] opt);
    return FAST ? (opt >= OPT_DIV && opt <= OPT_REMU) : (opt >= OPT_MUL && opt <= OPT_REMU);
  endfunction

  // Reference model from the instruction set semantics.
  function automatic logic [31:0] ref_alu(input logic [5:0] opt, input logic [31:0] a, v2, imm);
    logic [31:0] b;
    int sa, sb;
    logic [63:0] p;
    b  = (opt >= 6'd10 && opt <= 6'd18) ? imm : v2;
    sa = $signed(a);
    sb = $signed(b);
    p  = 64'd0;
    case (opt)
      6'd0, 6'd10:  return a + b;
      6'd1:         return a - b;
      6'd2, 6'd16:  return a << b[4:0];
      6'd3, 6'd11:  return (sa < sb) ? 32'd1 : 32'd0;
      6'd4, 6'd12:  return (a < b) ? 32'd1 : 32'd0;
      6'd5, 6'd13:  return a ^ b;
      6'd6, 6'd17:  return a >> b[4:0];
      6'd7, 6'd18:  return 32'(sa >>> b[4:0]);
      6'd8, 6'd14:  return a | b;
      6'd9, 6'd15:  return a & b;
      6'd19:        return (a == b) ? 32'd1 : 32'd0;
      6'd20:        return (a != b) ? 32'd1 : 32'd0;
      6'd21:        return (sa < sb) ? 32'd1 : 32'd0;
      6'd22:        return (sa >= sb) ? 32'd1 : 32'd0;
      6'd23:        return (a < b) ? 32'd1 : 32'd0;
      6'd24:        return (a >= b) ? 32'd1 : 32'd0;
      6'd25:        return a * b;
      6'd26: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
      6'd27: begin p = 64'(longint'(sa) * longint'({32'd0, b})); return p[63:32]; end
      6'd28: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      6'd29: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      6'd30:        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      6'd31: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      6'd32:        return (b == 32'd0) ? a : a % b;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] opt, input logic [31:0] a, b, imm, input logic [4:0] rob);
    alu_ena = 1'b1; alu_opt = opt; alu_val1 = a; alu_val2 = b; alu_imm = imm; alu_rob_idx = rob;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; alu_rb = 1'b0; alu_ena = 1'b0; alu_opt = 6'd0;
    alu_val1 = 32'd0; alu_val2 = 32'd0; alu_imm = 32'd0; alu_rob_idx = 5'd0;
    repeat (3) tick();
    checks++;
    if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val, alu_busy} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: valid=%b src=%0d val=%h busy=%b, want 0/0/0/0",
               cdb_alu_valid, cdb_alu_src, cdb_alu_val, alu_busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_directed();
    issue(OPT_ADD, 32'd5, 32'd7, 32'd0, 5'd3);
    tick();
    alu_ena = 1'b0;
    checks++;
    if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {1'b1, 5'd3, 32'd12}) begin
      errors++;
      $display("FAIL add_n1: valid=%b src=%0d val=%h, want 1/3/c", cdb_alu_valid, cdb_alu_src, cdb_alu_val);
    end
    tick();
    checks++;
    if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {1'b0, 5'd3, 32'd12}) begin
      errors++;
      $display("FAIL add_n2_hold: valid=%b src=%0d val=%h, want 0/3/c", cdb_alu_valid, cdb_alu_src, cdb_alu_val);
    end
    issue(OPT_SRAI, 32'h8000_0000, 32'h1234_5678, 32'd4, 5'd7);
    tick();
    checks++;
    if (cdb_alu_val !== 32'hF800_0000 || cdb_alu_valid !== 1'b1) begin
      errors++;
      $display("FAIL srai: val=%h valid=%b, want f8000000/1", cdb_alu_val, cdb_alu_valid);
    end
    issue(OPT_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd8);
    tick();
    alu_ena = 1'b0;
    checks++;
    if (cdb_alu_val !== 32'd1 || cdb_alu_src !== 5'd8) begin
      errors++;
      $display("FAIL bltu: val=%h src=%0d, want 1/8", cdb_alu_val, cdb_alu_src);
    end
  endtask

  task automatic test_random_single();
    logic [31:0] exp_val, last_val;
    logic [4:0]  exp_src, last_src;
    logic [5:0]  opt;
    bit          fired;
    last_val = cdb_alu_val;
    last_src = cdb_alu_src;
    for (int i = 0; i < 200; i++) begin
      fired = ($urandom_range(0, 7) != 0);
      opt   = 6'($urandom_range(0, FAST ? 28 : 24));
      issue(opt, rnd_word(), rnd_word(), rnd_word(), 5'($urandom));
      alu_ena = fired;
      exp_val = fired ? ref_alu(opt, alu_val1, alu_val2, alu_imm) : last_val;
      exp_src = fired ? alu_rob_idx : last_src;
      tick();
      checks++;
      if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {fired, exp_src, exp_val}) begin
        errors++;
        $display("FAIL rand_single op=%0d: valid=%b src=%0d val=%h, want %b/%0d/%h",
                 opt, cdb_alu_valid, cdb_alu_src, cdb_alu_val, fired, exp_src, exp_val);
      end
      last_val = exp_val;
      last_src = exp_src;
    end
    alu_ena = 1'b0;
    tick();
  endtask

  // Issue one op, follow it to its CDB pulse and check busy, latency, tag and value.
  task automatic run_multi(input logic [5:0] opt, input logic [31:0] a, b, input logic [4:0] rob,
                           input logic [31:0] exp_val);
    int lat, bad_busy;
    int exp_lat;
    exp_lat = is_multi(opt) ? 34 : 1;
    issue(opt, a, b, 32'd0, rob);
    #1;
    checks++;
    if (alu_busy !== is_multi(opt)) begin
      errors++;
      $display("FAIL busy_issue op=%0d: busy=%b want %b", opt, alu_busy, is_multi(opt));
    end
    tick();
    alu_ena = 1'b0;
    lat = 1;
    bad_busy = 0;
    while (cdb_alu_valid !== 1'b1 && lat < 60) begin
      if (alu_busy !== 1'b1) bad_busy++;
      tick();
      lat++;
    end
    checks++;
    if (lat != exp_lat || bad_busy != 0 || alu_busy !== 1'b0) begin
      errors++;
      $display("FAIL latency op=%0d: lat=%0d busy_gaps=%0d busy_end=%b, want lat=%0d gaps=0 busy_end=0",
               opt, lat, bad_busy, alu_busy, exp_lat);
    end
    checks++;
    if ({cdb_alu_src, cdb_alu_val} !== {rob, exp_val}) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: src=%0d val=%h, want %0d/%h",
               opt, a, b, cdb_alu_src, cdb_alu_val, rob, exp_val);
    end
  endtask

  task automatic test_multi_directed();
    run_multi(OPT_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    tick();
    checks++;
    if (cdb_alu_valid !== 1'b0) begin
      errors++;
      $display("FAIL div_pulse_width: valid=%b want 0", cdb_alu_valid);
    end
    run_multi(OPT_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
    run_multi(OPT_DIVU, 32'd9, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_multi(OPT_REM, 32'd9, 32'd0, 5'd12, 32'd9);
    run_multi(OPT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_multi(OPT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
    run_multi(OPT_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE);
  endtask

  task automatic test_random_multi();
    logic [5:0]  opt;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      opt = 6'($urandom_range(25, 32));
      a = rnd_word();
      b = rnd_word();
      run_multi(opt, a, b, 5'($urandom), ref_alu(opt, a, b, 32'd0));
    end
  endtask

  task automatic test_violation();
    int pulses, first;
    issue(OPT_DIV, 32'd100, 32'd7, 32'd0, 5'd20);
    tick();
    alu_ena = 1'b0;
    pulses = 0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      if (cdb_alu_valid === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 5) issue(OPT_ADD, 32'd1, 32'd1, 32'd0, 5'd21);
      tick();
      alu_ena = 1'b0;
    end
    checks++;
    if (pulses != 1 || first != 34 || cdb_alu_val !== 32'd14 || cdb_alu_src !== 5'd20) begin
      errors++;
      $display("FAIL violation: pulses=%0d first=%0d val=%h src=%0d, want 1/34/e/20",
               pulses, first, cdb_alu_val, cdb_alu_src);
    end
  endtask

  task automatic test_rollback();
    int pulses;
    issue(OPT_DIV, 32'd50, 32'd3, 32'd0, 5'd22);
    tick();
    alu_ena = 1'b0;
    repeat (9) tick();
    alu_rb = 1'b1;
    tick();
    alu_rb = 1'b0;
    #1;
    checks++;
    if ({alu_busy, cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL rollback_n11: busy=%b valid=%b src=%0d val=%h, want 0/0/0/0",
               alu_busy, cdb_alu_valid, cdb_alu_src, cdb_alu_val);
    end
    tick();
    issue(OPT_ADD, 32'd20, 32'd22, 32'd0, 5'd23);
    tick();
    alu_ena = 1'b0;
    checks++;
    if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {1'b1, 5'd23, 32'd42}) begin
      errors++;
      $display("FAIL rollback_add: valid=%b src=%0d val=%h, want 1/23/2a", cdb_alu_valid, cdb_alu_src, cdb_alu_val);
    end
    pulses = 0;
    for (int c = 14; c <= 40; c++) begin
      tick();
      if (cdb_alu_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rollback_no_pulse: pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_rdy_stall();
    int c;
    int exp_lat;
    exp_lat = FAST ? 1 : 39;
    issue(OPT_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd24);
    tick();
    alu_ena = 1'b0;
    c = 1;
    while (cdb_alu_valid !== 1'b1 && c < 80) begin
      rdy = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
      tick();
      c++;
    end
    rdy = 1'b1;
    checks++;
    if (c != exp_lat || cdb_alu_val !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL rdy_stall_mulhu: lat=%0d val=%h, want %0d/fffffffe", c, cdb_alu_val, exp_lat);
    end
    tick();
    issue(OPT_ADDI, 32'd1, 32'd99, 32'd2, 5'd4);
    tick();
    rdy = 1'b0;
    issue(OPT_SUB, 32'd10, 32'd3, 32'd0, 5'd5);
    tick();
    checks++;
    if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {1'b1, 5'd4, 32'd3}) begin
      errors++;
      $display("FAIL rdy_freeze: valid=%b src=%0d val=%h, want 1/4/3", cdb_alu_valid, cdb_alu_src, cdb_alu_val);
    end
    rdy = 1'b1;
    alu_ena = 1'b0;
    tick();
    checks++;
    if ({cdb_alu_valid, cdb_alu_src, cdb_alu_val} !== {1'b0, 5'd4, 32'd3}) begin
      errors++;
      $display("FAIL rdy_release: valid=%b src=%0d val=%h, want 0/4/3", cdb_alu_valid, cdb_alu_src, cdb_alu_val);
    end
  endtask

  initial begin
    test_reset();
    test_single_directed();
    test_random_single();
    test_multi_directed();
    test_random_multi();
    test_violation();
    test_rollback();
    test_rdy_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
